// File: rtl/ps2_key_encoder.sv
// ps2_key_encoder: PS/2 keyboard serial receiver that produces the 11-bit
// toggle-style ps2_key event word ({toggle, pressed, extended, scancode}).
//
// Ports:
//   clk_sys    system clock
//   reset      synchronous, active-high
//   ps2_clk    asynchronous PS/2 clock line
//   ps2_data   asynchronous PS/2 data line
//   ps2_key    [10] toggle, [9] pressed, [8] extended, [7:0] scancode
//   frame_err  one-cycle pulse on parity error, stop-bit error or timeout
//
// Parameters: FILTER_LEN (clock glitch filter length), TIMEOUT (partial
// frame abandon time, in clk_sys cycles).
// Optional feature macro: PS2_KEY_PAUSE_EN -- when defined, the E1 Pause
// sequence produces a press/release pair of {ext, 8'h77}; otherwise the
// whole E1 sequence is discarded silently.

module ps2_key_encoder #(
  parameter int FILTER_LEN = 8,
  parameter int TIMEOUT    = 24000
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        ps2_clk,
  input  logic        ps2_data,
  output logic [10:0] ps2_key,
  output logic        frame_err
);

  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [FW-1:0] FILT_LAST = FW'(FILTER_LEN - 1);
  localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_E0,
    ST_F0,
    ST_E0F0,
    ST_E1SKIP
  } prefix_t;

  // ---------------------------------------------------------------------
  // Input conditioning: 2-flop synchronizers and clock glitch filter.
  // ---------------------------------------------------------------------
  logic [1:0]    clk_sync;
  logic [1:0]    data_sync;
  logic          filt_clk;
  logic [FW-1:0] filt_cnt;
  logic          fall_q;     // one-cycle strobe: filtered clock just fell
  logic          bit_smp;    // data captured at that filtered fall

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      clk_sync  <= 2'b11;
      data_sync <= 2'b11;
      filt_clk  <= 1'b1;
      filt_cnt  <= '0;
      fall_q    <= 1'b0;
      bit_smp   <= 1'b1;
    end else begin
      clk_sync  <= {clk_sync[0], ps2_clk};
      data_sync <= {data_sync[0], ps2_data};
      fall_q    <= 1'b0;
      // The filtered clock follows the synchronized clock only after the
      // new level has been seen on FILTER_LEN consecutive cycles; any
      // return to the old level restarts the count.
      if (clk_sync[1] != filt_clk) begin
        if (filt_cnt == FILT_LAST) begin
          filt_clk <= clk_sync[1];
          filt_cnt <= '0;
          if (!clk_sync[1]) begin
            fall_q  <= 1'b1;
            bit_smp <= data_sync[1];
          end
        end else begin
          filt_cnt <= filt_cnt + 1'b1;
        end
      end else begin
        filt_cnt <= '0;
      end
    end
  end

  // ---------------------------------------------------------------------
  // Frame receiver state and decode of the completing byte.
  // ---------------------------------------------------------------------
  logic [3:0]    bit_cnt;    // 0: waiting for start, 1..8 data, 9 parity, 10 stop
  logic [7:0]    shreg;
  logic          par_q;
  logic [TW-1:0] tmo_cnt;
  prefix_t       state;
  logic [2:0]    skip_cnt;

  logic stop_strobe;
  logic frame_good;
  logic frame_bad;
  logic tmo_hit;
  logic is_resp;
  logic evt_pressed;
  logic evt_ext;

  always_comb begin
    stop_strobe = fall_q && (bit_cnt == 4'd10);
    // Odd parity: data plus parity bit must contain an odd number of ones.
    frame_good  = stop_strobe && (^{shreg, par_q}) && bit_smp;
    frame_bad   = stop_strobe && !((^{shreg, par_q}) && bit_smp);
    tmo_hit     = !fall_q && (bit_cnt != 4'd0) && (tmo_cnt == TMO_LAST);
    is_resp     = (shreg == 8'h00) || (shreg == 8'hAA) || (shreg == 8'hEE) ||
                  (shreg == 8'hFA) || (shreg == 8'hFE) || (shreg == 8'hFF);
    evt_pressed = (state == ST_IDLE) || (state == ST_E0);
    evt_ext     = (state == ST_E0)   || (state == ST_E0F0);
  end

`ifdef PS2_KEY_PAUSE_EN
  logic [1:0] pause_dly;     // counts down to the synthetic Pause release
`endif

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      bit_cnt   <= 4'd0;
      shreg     <= 8'h00;
      par_q     <= 1'b0;
      tmo_cnt   <= '0;
      state     <= ST_IDLE;
      skip_cnt  <= 3'd0;
      ps2_key   <= 11'd0;
      frame_err <= 1'b0;
`ifdef PS2_KEY_PAUSE_EN
      pause_dly <= 2'd0;
`endif
    end else begin
      frame_err <= 1'b0;

      // Timeout counter only runs while a frame is in progress.
      if (fall_q || (bit_cnt == 4'd0)) begin
        tmo_cnt <= '0;
      end else if (!tmo_hit) begin
        tmo_cnt <= tmo_cnt + 1'b1;
      end

      // Bit counter and shift register.
      if (tmo_hit) begin
        bit_cnt <= 4'd0;
      end else if (fall_q) begin
        if (bit_cnt == 4'd0) begin
          // A high start bit is just line noise; keep waiting.
          if (!bit_smp) begin
            bit_cnt <= 4'd1;
          end
        end else if (bit_cnt <= 4'd8) begin
          shreg   <= {bit_smp, shreg[7:1]};   // LSB arrives first
          bit_cnt <= bit_cnt + 4'd1;
        end else if (bit_cnt == 4'd9) begin
          par_q   <= bit_smp;
          bit_cnt <= 4'd10;
        end else begin
          bit_cnt <= 4'd0;
        end
      end

      // Prefix state machine and event encoder.
      if (tmo_hit || frame_bad) begin
        frame_err <= 1'b1;
        state     <= ST_IDLE;
        skip_cnt  <= 3'd0;
      end else if (frame_good) begin
        if (state == ST_E1SKIP) begin
          // Bytes inside the Pause sequence are never decoded, even E1.
          skip_cnt <= skip_cnt - 3'd1;
          if (skip_cnt == 3'd1) begin
            state <= ST_IDLE;
`ifdef PS2_KEY_PAUSE_EN
            ps2_key   <= {~ps2_key[10], 1'b1, 1'b1, 8'h77};
            pause_dly <= 2'd2;
`endif
          end
        end else if (shreg == 8'hE1) begin
          state    <= ST_E1SKIP;
          skip_cnt <= 3'd7;
        end else if (is_resp) begin
          state <= ST_IDLE;
        end else if ((shreg == 8'hE0) && (state == ST_IDLE)) begin
          state <= ST_E0;
        end else if ((shreg == 8'hF0) && (state == ST_IDLE)) begin
          state <= ST_F0;
        end else if ((shreg == 8'hF0) && (state == ST_E0)) begin
          state <= ST_E0F0;
        end else begin
          ps2_key <= {~ps2_key[10], evt_pressed, evt_ext, shreg};
          state   <= ST_IDLE;
        end
      end

`ifdef PS2_KEY_PAUSE_EN
      // Release follows the press by exactly two cycles; no frame can
      // complete in that window, so it never collides with another event.
      if (pause_dly != 2'd0) begin
        pause_dly <= pause_dly - 2'd1;
        if (pause_dly == 2'd1) begin
          ps2_key <= {~ps2_key[10], 1'b0, 1'b1, 8'h77};
        end
      end
`endif
    end
  end

endmodule

// File: tb/tb_ps2_key_encoder.sv
module tb_ps2_key_encoder;

  localparam int FILTER_LEN = 8;
  localparam int TIMEOUT    = 1000;
  localparam int H          = 20;   // half period of the PS/2 clock, in clk_sys cycles

  logic        clk_sys = 1'b0;
  logic        reset   = 1'b1;
  logic        ps2_clk = 1'b1;
  logic        ps2_data = 1'b1;
  logic [10:0] ps2_key;
  logic        frame_err;

  ps2_key_encoder #(.FILTER_LEN(FILTER_LEN), .TIMEOUT(TIMEOUT)) dut (
    .clk_sys   (clk_sys),
    .reset     (reset),
    .ps2_clk   (ps2_clk),
    .ps2_data  (ps2_data),
    .ps2_key   (ps2_key),
    .frame_err (frame_err)
  );

  always #5 clk_sys = ~clk_sys;

  int cyc = 0;
  always @(posedge clk_sys) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Monitor: counts toggles and error pulses, remembers the last two events.
  int         ev_cnt = 0;
  int         err_cnt = 0;
  int         last_evt_cyc = 0;
  int         prev_evt_cyc = 0;
  logic [9:0] last_word = '0;
  logic [9:0] prev_word = '0;
  logic       prev_tog = 1'b0;

  always @(negedge clk_sys) begin
    if (reset) begin
      prev_tog = 1'b0;
    end else begin
      if (frame_err === 1'b1) err_cnt++;
      if (ps2_key[10] !== prev_tog) begin
        prev_tog     = ps2_key[10];
        ev_cnt++;
        prev_evt_cyc = last_evt_cyc;
        last_evt_cyc = cyc;
        prev_word    = last_word;
        last_word    = ps2_key[9:0];
        check("evt_with_err", {31'd0, frame_err}, 32'd0);
      end
    end
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk_sys);
    #1;
  endtask

  int stop_cyc = 0;

  task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop,
                            input int nbits);
    logic [10:0] fr;
    fr = {~bad_stop, (~^b) ^ bad_par, b, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      ps2_data = fr[i];
      wait_cyc(H);
      ps2_clk = 1'b0;
      if (i == 10) stop_cyc = cyc;
      wait_cyc(H);
      ps2_clk = 1'b1;
    end
    ps2_data = 1'b1;
    wait_cyc(30);
  endtask

  typedef struct {
    logic [7:0] code;
    bit         bad_par;
    bit         bad_stop;
    bit         evt;
    logic [9:0] word;
    int         errs;
  } vec_t;

  vec_t tbl[19];

  logic       exp_tog  = 1'b0;
  logic [9:0] exp_word = '0;
  int         e0, r0;

  initial begin
    tbl[0]  = '{8'h75, 0, 0, 1, 10'h275, 0};
    tbl[1]  = '{8'hF0, 0, 0, 0, 10'h000, 0};
    tbl[2]  = '{8'h75, 0, 0, 1, 10'h075, 0};
    tbl[3]  = '{8'hE0, 0, 0, 0, 10'h000, 0};
    tbl[4]  = '{8'h6B, 0, 0, 1, 10'h36B, 0};
    tbl[5]  = '{8'hE0, 0, 0, 0, 10'h000, 0};
    tbl[6]  = '{8'hF0, 0, 0, 0, 10'h000, 0};
    tbl[7]  = '{8'h6B, 0, 0, 1, 10'h16B, 0};
    tbl[8]  = '{8'h29, 1, 0, 0, 10'h000, 1};
    tbl[9]  = '{8'h29, 0, 0, 1, 10'h229, 0};
    tbl[10] = '{8'hF0, 0, 0, 0, 10'h000, 0};
    tbl[11] = '{8'h29, 0, 1, 0, 10'h000, 1};
    tbl[12] = '{8'h29, 0, 0, 1, 10'h229, 0};
    tbl[13] = '{8'hE0, 0, 0, 0, 10'h000, 0};
    tbl[14] = '{8'hAA, 0, 0, 0, 10'h000, 0};
    tbl[15] = '{8'h12, 0, 0, 1, 10'h212, 0};
    tbl[16] = '{8'hFA, 0, 0, 0, 10'h000, 0};
    tbl[17] = '{8'hE0, 0, 0, 0, 10'h000, 0};
    tbl[18] = '{8'h1C, 0, 0, 1, 10'h31C, 0};

    // Reset state
    wait_cyc(5);
    check("reset_key", {21'd0, ps2_key}, 32'd0);
    check("reset_err", {31'd0, frame_err}, 32'd0);
    reset = 1'b0;
    wait_cyc(20);

    // Table-driven frames
    for (int i = 0; i < 19; i++) begin
      e0 = ev_cnt;
      r0 = err_cnt;
      send_frame(tbl[i].code, tbl[i].bad_par, tbl[i].bad_stop, 11);
      if (tbl[i].evt) begin
        exp_tog  = ~exp_tog;
        exp_word = tbl[i].word;
        check($sformatf("latency[%0d]", i), last_evt_cyc - stop_cyc, FILTER_LEN + 3);
      end
      check($sformatf("events[%0d]", i), ev_cnt - e0, tbl[i].evt ? 1 : 0);
      check($sformatf("errs[%0d]", i), err_cnt - r0, tbl[i].errs);
      check($sformatf("key[%0d]", i), {21'd0, ps2_key}, {21'd0, exp_tog, exp_word});
    end

    // Timeout mid-frame, then recovery
    e0 = ev_cnt;
    r0 = err_cnt;
    send_frame(8'h16, 0, 0, 5);
    wait_cyc(TIMEOUT + 10);
    check("tmo_errs", err_cnt - r0, 1);
    check("tmo_events", ev_cnt - e0, 0);
    send_frame(8'h16, 0, 0, 11);
    exp_tog  = ~exp_tog;
    exp_word = 10'h216;
    check("tmo_recover_key", {21'd0, ps2_key}, {21'd0, exp_tog, exp_word});
    check("tmo_recover_errs", err_cnt - r0, 1);

    // Reset mid-frame discards everything silently
    r0 = err_cnt;
    send_frame(8'h3C, 0, 0, 6);
    reset = 1'b1;
    wait_cyc(3);
    reset = 1'b0;
    wait_cyc(2);
    check("midrst_key", {21'd0, ps2_key}, 32'd0);
    exp_tog  = 1'b0;
    exp_word = '0;
    wait_cyc(TIMEOUT + 10);
    check("midrst_errs", err_cnt - r0, 0);

    // Short clock glitch with data low must not look like a start bit
    ps2_data = 1'b0;
    ps2_clk  = 1'b0;
    wait_cyc(FILTER_LEN - 1);
    ps2_clk  = 1'b1;
    wait_cyc(5);
    ps2_data = 1'b1;
    wait_cyc(30);
    e0 = ev_cnt;
    send_frame(8'h1E, 0, 0, 11);
    exp_tog  = ~exp_tog;
    exp_word = 10'h21E;
    check("glitch_events", ev_cnt - e0, 1);
    check("glitch_key", {21'd0, ps2_key}, {21'd0, exp_tog, exp_word});
    check("glitch_errs", err_cnt - r0, 0);

    // Pause sequence
    e0 = ev_cnt;
    send_frame(8'hE1, 0, 0, 11);
    send_frame(8'h14, 0, 0, 11);
    send_frame(8'h77, 0, 0, 11);
    send_frame(8'hE1, 0, 0, 11);
    send_frame(8'hF0, 0, 0, 11);
    send_frame(8'h14, 0, 0, 11);
    send_frame(8'hF0, 0, 0, 11);
    send_frame(8'h77, 0, 0, 11);
`ifdef PS2_KEY_PAUSE_EN
    check("pause_events", ev_cnt - e0, 2);
    check("pause_press", {22'd0, prev_word}, 32'h377);
    check("pause_release", {22'd0, last_word}, 32'h177);
    check("pause_gap", last_evt_cyc - prev_evt_cyc, 2);
    exp_word = 10'h177;
`else
    check("pause_events", ev_cnt - e0, 0);
`endif
    check("pause_key", {21'd0, ps2_key}, {21'd0, exp_tog, exp_word});
    check("pause_errs", err_cnt - r0, 0);

    // Prefix state is back in IDLE afterwards
    send_frame(8'h75, 0, 0, 11);
    exp_tog  = ~exp_tog;
    exp_word = 10'h275;
    check("post_pause_key", {21'd0, ps2_key}, {21'd0, exp_tog, exp_word});

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
